// File: rtl/multicycle_ctrl_fsm.sv
// Moore control unit sequencing a multicycle MIPS-subset datapath
// (R-type add/sub/and, addi, lw, sw, beq, j) with programmable memory read wait.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state_dbg
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET       = 4'd0,
    S_FETCH       = 4'd1,
    S_FETCH_LATCH = 4'd2,
    S_DECODE      = 4'd3,
    S_EXEC_R      = 4'd4,
    S_WB_R        = 4'd5,
    S_EXEC_I      = 4'd6,
    S_WB_I        = 4'd7,
    S_MEM_ADDR    = 4'd8,
    S_MEM_READ    = 4'd9,
    S_MEM_WB      = 4'd10,
    S_MEM_WRITE   = 4'd11,
    S_BRANCH      = 4'd12,
    S_JUMP        = 4'd13
  } state_e;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;

  // The ALU zero flag is gated with pc_write_cond inside the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  // Map an R-type funct to its ALU operation; PASS marks an unsupported funct.
  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    case (f)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      default: r_alu_op = ALU_PASS;
    endcase
  endfunction

  // Next-state logic and memory wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET:       state_d = S_FETCH;
      S_FETCH: begin
        if (cnt_q == '0) state_d = S_FETCH_LATCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FETCH_LATCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        if (r_alu_op(funct) != ALU_PASS) state_d = S_WB_R;
        else                             state_d = S_FETCH;
      end
      S_WB_R:        state_d = S_FETCH;
      S_EXEC_I:      state_d = S_WB_I;
      S_WB_I:        state_d = S_FETCH;
      S_MEM_ADDR: begin
        case (opcode)
          OP_LW:   state_d = S_MEM_READ;
          OP_SW:   state_d = S_MEM_WRITE;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        if (cnt_q == '0) state_d = S_MEM_WB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_MEM_WB:      state_d = S_FETCH;
      S_MEM_WRITE:   state_d = S_FETCH;
      S_BRANCH:      state_d = S_FETCH;
      S_JUMP:        state_d = S_FETCH;
      default:       state_d = S_RESET;
    endcase
    // Fresh wait count on every entry into a memory-read state.
    if ((state_d == S_FETCH && state_q != S_FETCH) ||
        (state_d == S_MEM_READ && state_q != S_MEM_READ)) begin
      cnt_d = WAIT_LOAD;
    end
  end

  // Output decode of the upcoming state, so registered outputs track state_q exactly.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH_LATCH: begin
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b     = SRCB_IMM2;
        ctrl_d.alu_op        = ALU_ADD;
        ctrl_d.alu_out_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REG;
        ctrl_d.alu_op        = r_alu_op(funct);
        ctrl_d.alu_out_write = 1'b1;
      end
      S_WB_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_IMM;
        ctrl_d.alu_op        = ALU_ADD;
        ctrl_d.alu_out_write = 1'b1;
      end
      S_WB_I: begin
        ctrl_d.reg_write = 1'b1;
      end
      S_MEM_READ: begin
        ctrl_d.iord = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.iord   = 1'b1;
        ctrl_d.mem_wr = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REG;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_source     = PCSRC_ALUOUT;
        ctrl_d.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_source = PCSRC_JUMP;
        ctrl_d.pc_write  = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, wait counter and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign pc_write      = ctrl_q.pc_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign iord          = ctrl_q.iord;
  assign mem_wr        = ctrl_q.mem_wr;
  assign ir_write      = ctrl_q.ir_write;
  assign alu_out_write = ctrl_q.alu_out_write;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: two controllers (MEM_WAIT 1 and 3) run independent
// instruction streams; expected per-cycle outputs are queued and checked at negedge.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       a;
    logic [1:0] b;
    logic [2:0] op;
    logic [1:0] pcs;
    logic       pw, pwc, iord, mw, irw, aow, rw, rd, m2r;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [2];
  logic [5:0] opcode  [2];
  logic [5:0] funct   [2];
  logic       zero    [2];
  logic       alu_src_a [2];
  logic [1:0] alu_src_b [2];
  logic [2:0] alu_op    [2];
  logic [1:0] pc_source [2];
  logic       pc_write  [2];
  logic       pc_write_cond [2];
  logic       iord      [2];
  logic       mem_wr    [2];
  logic       ir_write  [2];
  logic       alu_out_write [2];
  logic       reg_write [2];
  logic       reg_dst   [2];
  logic       mem_to_reg [2];
  logic [3:0] state_dbg [2];

  multicycle_ctrl_fsm #(.MEM_WAIT(1)) dut0 (
    .clk(clk), .reset(rst[0]), .opcode(opcode[0]), .funct(funct[0]), .zero(zero[0]),
    .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
    .pc_source(pc_source[0]), .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]),
    .iord(iord[0]), .mem_wr(mem_wr[0]), .ir_write(ir_write[0]),
    .alu_out_write(alu_out_write[0]), .reg_write(reg_write[0]), .reg_dst(reg_dst[0]),
    .mem_to_reg(mem_to_reg[0]), .state_dbg(state_dbg[0])
  );

  multicycle_ctrl_fsm #(.MEM_WAIT(3)) dut1 (
    .clk(clk), .reset(rst[1]), .opcode(opcode[1]), .funct(funct[1]), .zero(zero[1]),
    .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
    .pc_source(pc_source[1]), .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]),
    .iord(iord[1]), .mem_wr(mem_wr[1]), .ir_write(ir_write[1]),
    .alu_out_write(alu_out_write[1]), .reg_write(reg_write[1]), .reg_dst(reg_dst[1]),
    .mem_to_reg(mem_to_reg[1]), .state_dbg(state_dbg[1])
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t act(input int k);
    exp_t e;
    e.st = state_dbg[k];  e.a = alu_src_a[k];   e.b = alu_src_b[k];
    e.op = alu_op[k];     e.pcs = pc_source[k]; e.pw = pc_write[k];
    e.pwc = pc_write_cond[k]; e.iord = iord[k]; e.mw = mem_wr[k];
    e.irw = ir_write[k];  e.aow = alu_out_write[k]; e.rw = reg_write[k];
    e.rd = reg_dst[k];    e.m2r = mem_to_reg[k];
    return e;
  endfunction

  // Expected outputs while the controller is in a given state.
  function automatic exp_t step_out(input int st, input logic [2:0] rop);
    exp_t e = '0;
    e.st = 4'(st);
    case (st)
      2:  begin e.irw = 1; e.pw = 1; e.b = 2'b01; e.op = 3'b001; end
      3:  begin e.b = 2'b11; e.op = 3'b001; e.aow = 1; end
      4:  begin e.a = 1; e.b = 2'b00; e.op = rop; e.aow = 1; end
      5:  begin e.rw = 1; e.rd = 1; end
      6, 8: begin e.a = 1; e.b = 2'b10; e.op = 3'b001; e.aow = 1; end
      7:  e.rw = 1;
      9:  e.iord = 1;
      10: begin e.rw = 1; e.m2r = 1; end
      11: begin e.iord = 1; e.mw = 1; end
      12: begin e.a = 1; e.op = 3'b010; e.pcs = 2'b01; e.pwc = 1; end
      13: begin e.pcs = 2'b10; e.pw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input int k, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %h (state %0d) required %h (state %0d)",
               name, k, $time, got, got.st, want, want.st);
    end
  endtask

  task automatic check_int(input string name, input int k, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %0d required %0d", name, k, $time, got, want);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every non-reset cycle must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t want;
    for (int k = 0; k < 2; k++) begin
      if (rst[k] === 1'b0) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          failures++;
          $display("FAIL underflow dut%0d t=%0t: got state %0d required queued expectation",
                   k, $time, state_dbg[k]);
        end else begin
          want = (k == 0) ? q0.pop_front() : q1.pop_front();
          check("cycle", k, act(k), want);
        end
      end
    end
  end

  // Issue one instruction; called one time unit into its first FETCH cycle.
  // With abort set, reset is asserted in the instruction's final state.
  task automatic issue(input int k, input logic [5:0] op, input logic [5:0] fn, input bit abort);
    int   w = (k == 0) ? 1 : 3;
    int   n;
    exp_t seq[$];
    opcode[k] = op;
    funct[k]  = fn;
    zero[k]   = 1'($urandom);
    for (int i = 0; i < w; i++) seq.push_back(step_out(1, 3'b000));
    seq.push_back(step_out(2, 3'b000));
    seq.push_back(step_out(3, 3'b000));
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   begin seq.push_back(step_out(4, 3'b001)); seq.push_back(step_out(5, 3'b000)); end
          6'h22:   begin seq.push_back(step_out(4, 3'b010)); seq.push_back(step_out(5, 3'b000)); end
          6'h24:   begin seq.push_back(step_out(4, 3'b011)); seq.push_back(step_out(5, 3'b000)); end
          default: seq.push_back(step_out(4, 3'b000));
        endcase
      end
      6'h08: begin seq.push_back(step_out(6, 3'b000)); seq.push_back(step_out(7, 3'b000)); end
      6'h23: begin
        seq.push_back(step_out(8, 3'b000));
        for (int i = 0; i < w; i++) seq.push_back(step_out(9, 3'b000));
        seq.push_back(step_out(10, 3'b000));
      end
      6'h2B: begin seq.push_back(step_out(8, 3'b000)); seq.push_back(step_out(11, 3'b000)); end
      6'h04: seq.push_back(step_out(12, 3'b000));
      6'h02: seq.push_back(step_out(13, 3'b000));
      default: ;
    endcase
    n = abort ? seq.size() - 1 : seq.size();
    for (int i = 0; i < n; i++) push(k, seq[i]);
    repeat (n) @(posedge clk);
    #1;
    if (abort) begin
      check_int("abort_state", k, int'(state_dbg[k]), int'(seq[n].st));
      rst[k] = 1'b1;
      #1;
      check("reset_immediate", k, act(k), '0);
      @(posedge clk); #1;
      check("reset_held", k, act(k), '0);
      push(k, step_out(0, 3'b000));
      rst[k] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  function automatic bit defined_op(input logic [5:0] op);
    return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
  endfunction

  task automatic run(input int k);
    logic [5:0] op, fn;
    rst[k] = 1'b1; opcode[k] = '0; funct[k] = '0; zero[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in_reset", k, act(k), '0);
    push(k, step_out(0, 3'b000));
    rst[k] = 1'b0;
    @(posedge clk); #1;
    // Directed: each instruction class plus boundary cases.
    issue(k, 6'h00, 6'h20, 1'b0);
    issue(k, 6'h23, 6'h15, 1'b0);
    issue(k, 6'h2B, 6'h00, 1'b0);
    issue(k, 6'h04, 6'h00, 1'b0);
    issue(k, 6'h04, 6'h3F, 1'b0);
    issue(k, 6'h02, 6'h00, 1'b0);
    issue(k, 6'h3F, 6'h20, 1'b0);
    issue(k, 6'h00, 6'h00, 1'b0);
    issue(k, 6'h00, 6'h22, 1'b0);
    issue(k, 6'h00, 6'h24, 1'b0);
    issue(k, 6'h08, 6'h20, 1'b0);
    issue(k, 6'h2B, 6'h20, 1'b1);
    issue(k, 6'h00, 6'h20, 1'b1);
    issue(k, 6'h23, 6'h00, 1'b0);
    // Random instruction mix.
    for (int i = 0; i < 120; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 9))
        0: op = 6'h00;
        1: begin op = 6'h00; fn = 6'h22; end
        2: begin op = 6'h00; fn = 6'h24; end
        3: begin
          op = 6'h00;
          fn = 6'h20;
          while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) fn = 6'($urandom);
        end
        4: op = 6'h08;
        5: op = 6'h23;
        6: op = 6'h2B;
        7: op = 6'h04;
        8: op = 6'h02;
        default: begin
          op = 6'h00;
          while (defined_op(op)) op = 6'($urandom);
        end
      endcase
      if (op == 6'h00 && i % 10 == 0) fn = 6'h20;
      issue(k, op, fn, (i % 37 == 36) ? 1'b1 : 1'b0);
    end
    rst[k] = 1'b1;
    #1;
    check_int("queue_drained", k, (k == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    fork
      run(0);
      run(1);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t: got no completion required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
